// File: rtl/nv_nvdla_pdp_core_med1d_pack.sv
// nv_nvdla_pdp_core_med1d_pack
//
// Front end of the PDP 1-D median path. Slides a 3-sample window along each line of uint8
// samples, sorts the window, sends the sorted 3-bit MSBs to the med1d LUT encoder and packs
// four windows (7-bit LUT code + sorted 5-bit LSBs) into one 88-bit output word.
//
// Ports:
//   nvdla_core_clk, nvdla_core_rst   clock, synchronous active-high reset
//   pix_in_pvld/prdy/pd              input sample stream (uint8, raster order within a line)
//   lut_encoding                     LUT enable, high while a sorted window is presented
//   lut_msb_a/b/c                    sorted MSBs (lo, mid, hi) to the LUT
//   lut_code                         7-bit triplet code, combinational return
//   med_out_pvld/prdy/pd             packed output word, four 22-bit slots
//   med_out_mask                     slot n valid (contiguous from slot 0)
//   med_out_last                     final word of a line
//   med_code_err                     sticky out-of-range LUT code flag
//
// Build option: define NVDLA_PDP_MED1D_CODE_CHK_EN to build the LUT code range checker;
// otherwise med_code_err is tied low.
//
// Slot layout: [6:0] code, [11:7] lo[4:0], [16:12] mid[4:0], [21:17] hi[4:0].

module nv_nvdla_pdp_core_med1d_pack #(
  parameter int LINE_W = 16,
  localparam int COL_W = $clog2(LINE_W)
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        pix_in_pvld,
  output logic        pix_in_prdy,
  input  logic [7:0]  pix_in_pd,
  output logic        lut_encoding,
  output logic [2:0]  lut_msb_a,
  output logic [2:0]  lut_msb_b,
  output logic [2:0]  lut_msb_c,
  input  logic [6:0]  lut_code,
  output logic        med_out_pvld,
  input  logic        med_out_prdy,
  output logic [87:0] med_out_pd,
  output logic [3:0]  med_out_mask,
  output logic        med_out_last,
  output logic        med_code_err
);

  logic adv;
  logic accept;
  logic win_form;
  logic col_last;

  // The whole pipeline stalls as one unit on output backpressure.
  assign adv         = !med_out_pvld || med_out_prdy;
  assign pix_in_prdy = adv;
  assign accept      = pix_in_pvld && adv;

  // ---------------------------------------------------------------------------------------
  // Stage 0: sample history and column tracking
  // ---------------------------------------------------------------------------------------
  logic [7:0]       s1;
  logic [7:0]       s2;
  logic [COL_W-1:0] col;

  assign col_last = (col == COL_W'(LINE_W - 1));
  assign win_form = accept && (col >= COL_W'(2));

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      s1  <= 8'd0;
      s2  <= 8'd0;
      col <= '0;
    end else if (accept) begin
      s2  <= s1;
      s1  <= pix_in_pd;
      col <= col_last ? '0 : col + COL_W'(1);
    end
  end

  // Three compare-swaps; strict '>' leaves equal samples in arrival order.
  logic [7:0] a1, b1, b2, c2, a3, b3;

  always_comb begin
    a1 = s2;
    b1 = s1;
    if (s2 > s1) begin
      a1 = s1;
      b1 = s2;
    end
    b2 = b1;
    c2 = pix_in_pd;
    if (b1 > pix_in_pd) begin
      b2 = pix_in_pd;
      c2 = b1;
    end
    a3 = a1;
    b3 = b2;
    if (a1 > b2) begin
      a3 = b2;
      b3 = a1;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Stage 1: sorted window presented to the LUT
  // ---------------------------------------------------------------------------------------
  logic [7:0] lo_q;
  logic [7:0] mid_q;
  logic [7:0] hi_q;
  logic       win_vld;
  logic       line_end;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      lo_q     <= 8'd0;
      mid_q    <= 8'd0;
      hi_q     <= 8'd0;
      win_vld  <= 1'b0;
      line_end <= 1'b0;
    end else if (adv) begin
      win_vld <= win_form;
      if (win_form) begin
        lo_q     <= a3;
        mid_q    <= b3;
        hi_q     <= c2;
        line_end <= col_last;
      end
    end
  end

  assign lut_encoding = win_vld;
  assign lut_msb_a    = win_vld ? lo_q[7:5]  : 3'd0;
  assign lut_msb_b    = win_vld ? mid_q[7:5] : 3'd0;
  assign lut_msb_c    = win_vld ? hi_q[7:5]  : 3'd0;

  // ---------------------------------------------------------------------------------------
  // Packing: slots 0..2 wait in pack_q; slot 3 or a line-end window flushes the word.
  // ---------------------------------------------------------------------------------------
  logic [21:0]       cur_slot;
  logic [2:0][21:0]  pack_q;
  logic [1:0]        slot_cnt;
  logic              word_done;
  logic [87:0]       word_d;
  logic [3:0]        mask_d;

  assign cur_slot  = {hi_q[4:0], mid_q[4:0], lo_q[4:0], lut_code};
  assign word_done = win_vld && ((slot_cnt == 2'd3) || line_end);

  always_comb begin
    word_d    = '0;
    mask_d    = '0;
    word_d[21:0] = (slot_cnt == 2'd0) ? cur_slot : pack_q[0];
    mask_d[0]    = 1'b1;
    if (slot_cnt >= 2'd1) begin
      word_d[43:22] = (slot_cnt == 2'd1) ? cur_slot : pack_q[1];
      mask_d[1]     = 1'b1;
    end
    if (slot_cnt >= 2'd2) begin
      word_d[65:44] = (slot_cnt == 2'd2) ? cur_slot : pack_q[2];
      mask_d[2]     = 1'b1;
    end
    if (slot_cnt == 2'd3) begin
      word_d[87:66] = cur_slot;
      mask_d[3]     = 1'b1;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      slot_cnt <= 2'd0;
      pack_q   <= '0;
    end else if (adv && win_vld) begin
      if (word_done) begin
        slot_cnt <= 2'd0;
      end else begin
        slot_cnt <= slot_cnt + 2'd1;
        case (slot_cnt)
          2'd0:    pack_q[0] <= cur_slot;
          2'd1:    pack_q[1] <= cur_slot;
          2'd2:    pack_q[2] <= cur_slot;
          default: ;
        endcase
      end
    end
  end

  // Output register: holds while stalled, may reload on the edge the old word is taken.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      med_out_pvld <= 1'b0;
      med_out_pd   <= '0;
      med_out_mask <= '0;
      med_out_last <= 1'b0;
    end else if (adv) begin
      med_out_pvld <= word_done;
      if (word_done) begin
        med_out_pd   <= word_d;
        med_out_mask <= mask_d;
        med_out_last <= line_end;
      end
    end
  end

`ifdef NVDLA_PDP_MED1D_CODE_CHK_EN
  logic code_err_q;

  // Only 120 sorted triplets exist, so codes above 119 indicate a LUT fault.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      code_err_q <= 1'b0;
    end else if (lut_encoding && (lut_code > 7'd119)) begin
      code_err_q <= 1'b1;
    end
  end

  assign med_code_err = code_err_q;
`else
  assign med_code_err = 1'b0;
`endif

endmodule

// File: tb/tb_nv_nvdla_pdp_core_med1d_pack.sv
// Directed bench for nv_nvdla_pdp_core_med1d_pack (LINE_W = 16, 14 windows per line).
// A lexicographic triplet LUT model is attached to the LUT port; output words are captured
// by a monitor and compared with a golden packer built from the line samples.

module tb_nv_nvdla_pdp_core_med1d_pack;

  localparam int LW   = 16;
  localparam int NWIN = LW - 2;
`ifdef NVDLA_PDP_MED1D_CODE_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_in_pvld = 1'b0;
  logic        pix_in_prdy;
  logic [7:0]  pix_in_pd = 8'd0;
  logic        lut_encoding;
  logic [2:0]  lut_msb_a, lut_msb_b, lut_msb_c;
  logic [6:0]  lut_code;
  logic        med_out_pvld;
  logic        med_out_prdy = 1'b1;
  logic [87:0] med_out_pd;
  logic [3:0]  med_out_mask;
  logic        med_out_last;
  logic        med_code_err;
  logic        force_bad = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] line_a [LW] = '{8'h00, 8'h20, 8'h40, 8'hE3, 8'h05, 8'h61, 8'h7F, 8'h80,
                              8'hFF, 8'h12, 8'h34, 8'h56, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [7:0] line_b [LW] = '{8'h11, 8'hC8, 8'h3C, 8'h3C, 8'hA5, 8'h5A, 8'h01, 8'hFE,
                              8'h77, 8'h88, 8'h99, 8'h10, 8'hE0, 8'h42, 8'h24, 8'h7E};
  logic [7:0] gl [LW];

  logic [87:0] q_pd [$];
  logic [3:0]  q_mask [$];
  logic        q_last [$];

  always #5 clk = ~clk;

  // Sorted triplets (i <= j <= k) numbered in lexicographic order.
  function automatic logic [6:0] lut_model(input logic [2:0] a, input logic [2:0] b,
                                           input logic [2:0] c);
    int code;
    logic [6:0] r;
    code = 0;
    r    = 7'd127;
    for (int i = 0; i < 8; i++)
      for (int j = i; j < 8; j++)
        for (int k = j; k < 8; k++) begin
          if (i == int'(a) && j == int'(b) && k == int'(c)) r = 7'(code);
          code++;
        end
    return r;
  endfunction

  assign lut_code = force_bad ? 7'd127 : lut_model(lut_msb_a, lut_msb_b, lut_msb_c);

  nv_nvdla_pdp_core_med1d_pack #(.LINE_W(LW)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .pix_in_pvld    (pix_in_pvld),
    .pix_in_prdy    (pix_in_prdy),
    .pix_in_pd      (pix_in_pd),
    .lut_encoding   (lut_encoding),
    .lut_msb_a      (lut_msb_a),
    .lut_msb_b      (lut_msb_b),
    .lut_msb_c      (lut_msb_c),
    .lut_code       (lut_code),
    .med_out_pvld   (med_out_pvld),
    .med_out_prdy   (med_out_prdy),
    .med_out_pd     (med_out_pd),
    .med_out_mask   (med_out_mask),
    .med_out_last   (med_out_last),
    .med_code_err   (med_code_err)
  );

  always @(negedge clk) begin
    if (!rst && med_out_pvld && med_out_prdy) begin
      q_pd.push_back(med_out_pd);
      q_mask.push_back(med_out_mask);
      q_last.push_back(med_out_last);
    end
  end

  // Golden word w of the line held in gl.
  function automatic void gold(input int w, output logic [87:0] pd, output logic [3:0] mask,
                               output logic last);
    logic [7:0] x, y, z, lo, hi, mid;
    pd   = '0;
    mask = '0;
    last = (w == (NWIN - 1) / 4);
    for (int n = 0; n < 4; n++) begin
      if (4 * w + n < NWIN) begin
        x   = gl[4 * w + n];
        y   = gl[4 * w + n + 1];
        z   = gl[4 * w + n + 2];
        lo  = (x < y) ? ((x < z) ? x : z) : ((y < z) ? y : z);
        hi  = (x > y) ? ((x > z) ? x : z) : ((y > z) ? y : z);
        mid = 8'(int'(x) + int'(y) + int'(z) - int'(lo) - int'(hi));
        pd[22 * n +: 22] = {hi[4:0], mid[4:0], lo[4:0], lut_model(lo[7:5], mid[7:5], hi[7:5])};
        mask[n] = 1'b1;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    int   k;
    logic ok;
    pix_in_pvld = 1'b1;
    pix_in_pd   = v;
    k = 0;
    do begin
      #1;
      ok = pix_in_prdy;
      step();
      k++;
    end while (!ok && k < 50);
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $error("FAIL send_timeout: observed no accept expected accept");
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_prdy"}, 88'(pix_in_prdy), 88'd1);
    check({tag, "_pvld"}, 88'(med_out_pvld), 88'd0);
    check({tag, "_pd"}, med_out_pd, 88'd0);
    check({tag, "_mask"}, 88'(med_out_mask), 88'd0);
    check({tag, "_last"}, 88'(med_out_last), 88'd0);
    check({tag, "_enc"}, 88'(lut_encoding), 88'd0);
    check({tag, "_msb"}, 88'({lut_msb_a, lut_msb_b, lut_msb_c}), 88'd0);
    check({tag, "_err"}, 88'(med_code_err), 88'd0);
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (q_pd.size() < n && k < 100) begin
      step();
      k++;
    end
    check("drain_count", 88'(q_pd.size()), 88'(n));
  endtask

  task automatic check_words(input string tag, input int nw);
    logic [87:0] epd;
    logic [3:0]  emask;
    logic        elast;
    for (int w = 0; w < nw; w++) begin
      gold(w, epd, emask, elast);
      if (q_pd.size() > 0) begin
        check($sformatf("%s_w%0d_pd", tag, w), q_pd.pop_front(), epd);
        check($sformatf("%s_w%0d_mask", tag, w), 88'(q_mask.pop_front()), 88'(emask));
        check($sformatf("%s_w%0d_last", tag, w), 88'(q_last.pop_front()), 88'(elast));
      end
    end
  endtask

  task automatic load_gl(input int which);
    for (int i = 0; i < LW; i++) gl[i] = (which == 0) ? line_a[i] : line_b[i];
  endtask

  logic [87:0] epd;
  logic [3:0]  emask;
  logic        elast;

  initial begin
    // Reset state
    repeat (3) step();
    check_reset("reset");
    rst = 1'b0;
    step();

    // Line A, watching the LUT port after the 3rd and 6th samples
    load_gl(0);
    for (int i = 0; i < 3; i++) send(line_a[i]);
    check("lut1_enc", 88'(lut_encoding), 88'd1);
    check("lut1_msb", 88'({lut_msb_a, lut_msb_b, lut_msb_c}), 88'({3'd0, 3'd1, 3'd2}));
    for (int i = 3; i < 6; i++) send(line_a[i]);
    check("lut2_msb", 88'({lut_msb_a, lut_msb_b, lut_msb_c}), 88'({3'd0, 3'd3, 3'd7}));
    for (int i = 6; i < LW; i++) send(line_a[i]);

    // Line B back to back, with a 5-cycle output stall once word 0 is valid
    load_gl(1);
    for (int i = 0; i < 7; i++) send(line_b[i]);
    gold(0, epd, emask, elast);
    med_out_prdy = 1'b0;
    pix_in_pd    = line_b[7];
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_pvld", 88'(med_out_pvld), 88'd1);
      check("stall_prdy", 88'(pix_in_prdy), 88'd0);
      check("stall_pd", med_out_pd, epd);
      check("stall_mask", 88'(med_out_mask), 88'(emask));
      check("stall_last", 88'(med_out_last), 88'(elast));
      step();
    end
    med_out_prdy = 1'b1;
    for (int i = 7; i < LW; i++) send(line_b[i]);
    pix_in_pvld = 1'b0;
    wait_words(8);

    // Hand-computed fields of line A
    if (q_pd.size() >= 4) begin
      check("a_w0_slot0", 88'(q_pd[0][21:0]), 88'd9);
      check("a_w0_slot3", 88'(q_pd[0][87:66]), 88'({5'd3, 5'd1, 5'd5, 7'd25}));
      check("a_w3_mask", 88'(q_mask[3]), 88'(4'b0011));
      check("a_w3_last", 88'(q_last[3]), 88'd1);
      check("a_w3_hi_zero", 88'(q_pd[3][87:44]), 88'd0);
      check("a_w1_last", 88'(q_last[1]), 88'd0);
    end
    load_gl(0);
    check_words("lineA", 4);
    load_gl(1);
    check_words("lineB", 4);

    // Reset after 7 samples of a line
    load_gl(0);
    for (int i = 0; i < 7; i++) send(line_a[i]);
    rst         = 1'b1;
    pix_in_pvld = 1'b0;
    step();
    check_reset("midreset");
    rst = 1'b0;
    q_pd.delete();
    q_mask.delete();
    q_last.delete();
    step();
    for (int i = 0; i < LW; i++) send(line_a[i]);
    pix_in_pvld = 1'b0;
    wait_words(4);
    check_words("postreset", 4);

    // Out-of-range LUT code for one window
    for (int i = 0; i < 3; i++) send(line_a[i]);
    pix_in_pvld = 1'b0;
    check("err_before", 88'(med_code_err), 88'd0);
    force_bad = 1'b1;
    step();
    force_bad = 1'b0;
    check("err_set", 88'(med_code_err), 88'(EXP_ERR));
    repeat (3) step();
    check("err_sticky", 88'(med_code_err), 88'(EXP_ERR));
    rst = 1'b1;
    step();
    check("err_cleared", 88'(med_code_err), 88'd0);
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
